// File: rtl/router_pkt_tx_pkg.sv
// Shared constants for the router source-side transmitter: default widths,
// the highest legal destination address and the transmitter state encodings.
package router_pkt_tx_pkg;

    // Default port widths and timing
    localparam int         DEF_DATA_W   = 8;
    localparam int         DEF_LEN_W    = 6;
    localparam logic [1:0] DEF_MAX_ADDR = 2'd2;
    localparam int         DEF_IDLE_GAP = 1;

    // Transmitter FSM encodings, kept as plain constants so the router FSM
    // and the sync block can share the same values
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_PLD  = 3'd2;
    localparam logic [2:0] ST_PAR  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

endpackage

// File: rtl/router_tx_parity.sv
// Running XOR accumulator for the packet parity byte. A load seeds it with
// the header, each fold XORs in one transmitted payload byte, and a clear
// returns it to zero once the parity byte has gone out.
module router_tx_parity #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              fold,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_value,
    input  logic [DATA_W-1:0] fold_value,
    output logic [DATA_W-1:0] parity
);

    // Accumulator register: clear wins over load, load wins over fold
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            parity <= '0;
        end else if (load) begin
            parity <= load_value;
        end else if (fold) begin
            parity <= parity ^ fold_value;
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Source-side packet transmitter for the 1x3 router. Frames each accepted
// request as header, payload bytes and a parity byte, honours the router's
// busy back-pressure and pulls payload from a local valid/ready source.
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int         DATA_W   = DEF_DATA_W,
    parameter int         LEN_W    = DEF_LEN_W,
    parameter logic [1:0] MAX_ADDR = DEF_MAX_ADDR,
    parameter int         IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_active,
    output logic              done,
    output logic              err
);

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    logic [2:0]        state;
    logic [LEN_W-1:0]  rem;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] parity;
    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] pl_byte;
    logic              in_payload_phase;
    logic              accept;
    logic              start_legal;
    logic              start_ok;
    logic              underrun;
    logic              par_clear;

    assign header           = DATA_W'({payload_len, dest_addr});
    assign in_payload_phase = (state == ST_HDR) || (state == ST_PLD);
    assign accept           = !busy && (in_payload_phase || (state == ST_PAR));
    assign pl_ready         = !rst && !busy && in_payload_phase && (rem != '0);
    assign underrun         = pl_ready && !pl_valid;
    assign pl_byte          = pl_valid ? pl_data : '0;
    assign start_legal      = (payload_len != '0) && (dest_addr <= MAX_ADDR);
    assign start_ok         = (state == ST_IDLE) && start && start_legal;
    assign par_clear        = accept && (state == ST_PAR);

    router_tx_parity #(
        .DATA_W (DATA_W)
    ) u_parity (
        .clk        (clk),
        .rst        (rst),
        .load       (start_ok),
        .fold       (pl_ready),
        .clear      (par_clear),
        .load_value (header),
        .fold_value (pl_byte),
        .parity     (parity)
    );

    // Framing FSM with remaining-byte and gap counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rem       <= '0;
            gap_cnt   <= '0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (start_legal) begin
                            data_out  <= header;
                            pkt_valid <= 1'b1;
                            rem       <= payload_len;
                            tx_active <= 1'b1;
                            state     <= ST_HDR;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_HDR, ST_PLD: begin
                    if (underrun) begin
                        err <= 1'b1;
                    end
                    if (accept) begin
                        if (rem != '0) begin
                            data_out <= pl_byte;
                            rem      <= rem - 1'b1;
                            state    <= ST_PLD;
                        end else begin
                            data_out  <= parity;
                            pkt_valid <= 1'b0;
                            state     <= ST_PAR;
                        end
                    end
                end
                ST_PAR: begin
                    if (accept) begin
                        done     <= 1'b1;
                        data_out <= '0;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(IDLE_GAP - 1)) begin
                        tx_active <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    pkt_valid <= 1'b0;
                    tx_active <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
